assoc_ways: RTL

Parametrised N-way set-associative storage array for the cache datapath, generalising the fixed two-set way into configurable ways, sets, line length and widths. It adds per-set true-LRU replacement, invalid-first victim selection and a registered enable/ack handshake. The cache controller drives it; a miss response carries the victim's tag, dirty and data so the controller can decide on write-back.

---
 rtl/assoc_ways_pkg.sv | 26 ++
 rtl/lru_tracker.sv | 52 +++++
 rtl/assoc_ways.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/assoc_ways_pkg.sv
// Shared types and width helpers for the N-way associative storage array.
// Imported by assoc_ways and lru_tracker.
package assoc_ways_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESPOND
  } state_e;

  typedef struct packed {
    logic comp;
    logic write;
  } op_t;

  localparam int unsigned DEF_WAYS   = 2;
  localparam int unsigned DEF_SETS   = 4;
  localparam int unsigned DEF_WORDS  = 4;
  localparam int unsigned DEF_TAG_W  = 5;
  localparam int unsigned DEF_WORD_W = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// Per-set true-LRU ages (0 = MRU, WAYS-1 = LRU).
// Reset leaves way index as age so the top way is the first LRU victim.
module lru_tracker
  import assoc_ways_pkg::*;
#(
  parameter int unsigned WAYS = DEF_WAYS,
  parameter int unsigned SETS = DEF_SETS,
  localparam int unsigned WYW = idx_w(WAYS),
  localparam int unsigned IW  = idx_w(SETS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  set_i,
  input  logic           touch_i,
  input  logic [WYW-1:0] touch_way_i,
  output logic [WYW-1:0] lru_way_o
);

  logic [WYW-1:0] age_q [SETS][WAYS];
  logic [WYW-1:0] row_d [WAYS];
  logic [WYW-1:0] hit_age;

  always_comb begin
    hit_age = age_q[set_i][touch_way_i];
    for (int w = 0; w < WAYS; w++) begin
      row_d[w] = age_q[set_i][w];
      if (touch_way_i == WYW'(w))
        row_d[w] = '0;
      else if (age_q[set_i][w] < hit_age)
        row_d[w] = age_q[set_i][w] + 1'b1;
    end
  end

  always_comb begin
    lru_way_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[set_i][w] == WYW'(WAYS - 1))
        lru_way_o = WYW'(w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WYW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++)
        age_q[set_i][w] <= row_d[w];
    end
  end

endmodule

// File: rtl/assoc_ways.sv
// N-way set-associative tag/data array with LRU replacement.
// Three-cycle request: IDLE accepts, LOOKUP commits, RESPOND acks.
module assoc_ways
  import assoc_ways_pkg::*;
#(
  parameter int unsigned WAYS   = DEF_WAYS,
  parameter int unsigned SETS   = DEF_SETS,
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned WORD_W = DEF_WORD_W,
  localparam int unsigned IW  = idx_w(SETS),
  localparam int unsigned WDW = idx_w(WORDS),
  localparam int unsigned WYW = idx_w(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [IW-1:0]     index,
  input  logic [WDW-1:0]    word,
  input  logic              comp,
  input  logic              write,
  input  logic [WYW-1:0]    way_sel,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              busy,
  output logic              ack,
  output logic              hit,
  output logic [WYW-1:0]    way_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              dirty_out,
  output logic              valid_out,
  output logic [WORD_W-1:0] data_out
);

  state_e state_q, state_d;

  logic [IW-1:0]     rq_idx_q;
  logic [WDW-1:0]    rq_word_q;
  op_t               rq_op_q;
  logic [WYW-1:0]    rq_way_q;
  logic [TAG_W-1:0]  rq_tag_q;
  logic [WORD_W-1:0] rq_data_q;
  logic              rq_vld_q;

  logic              valid_mem_q [WAYS][SETS];
  logic              dirty_mem_q [WAYS][SETS];
  logic [TAG_W-1:0]  tag_mem_q   [WAYS][SETS];
  logic [WORD_W-1:0] data_mem_q  [WAYS][SETS][WORDS];

  logic              rsp_hit_q;
  logic [WYW-1:0]    rsp_way_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_dirty_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_data_q;

  logic           lk_hit, any_inv;
  logic [WYW-1:0] hit_way, inv_way, lru_way, victim, sel_way;
  logic           lookup, wr_data, wr_meta, set_dirty, touch;
  logic           accept;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    ack    = (state_q == S_RESPOND);
    lookup = (state_q == S_LOOKUP);
    accept = (state_q == S_IDLE) && enable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_idx_q  <= '0;
      rq_word_q <= '0;
      rq_op_q   <= '0;
      rq_way_q  <= '0;
      rq_tag_q  <= '0;
      rq_data_q <= '0;
      rq_vld_q  <= 1'b0;
    end else if (accept) begin
      rq_idx_q  <= index;
      rq_word_q <= word;
      rq_op_q   <= '{comp: comp, write: write};
      rq_way_q  <= way_sel;
      rq_tag_q  <= tag_in;
      rq_data_q <= data_in;
      rq_vld_q  <= valid_in;
    end
  end

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    lk_hit  = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem_q[w][rq_idx_q] &&
          tag_mem_q[w][rq_idx_q] == rq_tag_q) begin
        lk_hit  = 1'b1;
        hit_way = WYW'(w);
      end
      if (!valid_mem_q[w][rq_idx_q]) begin
        any_inv = 1'b1;
        inv_way = WYW'(w);
      end
    end
  end

  always_comb begin
    victim  = any_inv ? inv_way : lru_way;
    sel_way = rq_op_q.comp ? (lk_hit ? hit_way : victim) : rq_way_q;
    wr_data = lookup && rq_op_q.write && (!rq_op_q.comp || lk_hit);
    wr_meta = lookup && rq_op_q.write && !rq_op_q.comp;
    set_dirty = lookup && rq_op_q.write && rq_op_q.comp && lk_hit;
    touch = lookup && (rq_op_q.comp ? lk_hit
          : (rq_op_q.write && rq_word_q == WDW'(WORDS - 1)));
  end

  lru_tracker #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk         (clk),
    .rst         (rst),
    .set_i       (rq_idx_q),
    .touch_i     (touch),
    .touch_way_i (sel_way),
    .lru_way_o   (lru_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          valid_mem_q[w][s] <= 1'b0;
          dirty_mem_q[w][s] <= 1'b0;
        end
    end else if (wr_meta) begin
      valid_mem_q[sel_way][rq_idx_q] <= rq_vld_q;
      dirty_mem_q[sel_way][rq_idx_q] <= 1'b0;
    end else if (set_dirty) begin
      dirty_mem_q[sel_way][rq_idx_q] <= 1'b1;
    end
  end

  // Tag/data are not reset; commit strobes derive from the reset FSM.
  always_ff @(posedge clk) begin
    if (wr_data)
      data_mem_q[sel_way][rq_idx_q][rq_word_q] <= rq_data_q;
    if (wr_meta)
      tag_mem_q[sel_way][rq_idx_q] <= rq_tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_dirty_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (lookup) begin
      rsp_hit_q   <= rq_op_q.comp && lk_hit;
      rsp_way_q   <= sel_way;
      rsp_tag_q   <= tag_mem_q[sel_way][rq_idx_q];
      rsp_dirty_q <= dirty_mem_q[sel_way][rq_idx_q];
      rsp_valid_q <= valid_mem_q[sel_way][rq_idx_q];
      rsp_data_q  <= data_mem_q[sel_way][rq_idx_q][rq_word_q];
    end
  end

  always_comb begin
    hit       = rsp_hit_q;
    way_out   = rsp_way_q;
    tag_out   = rsp_tag_q;
    dirty_out = rsp_dirty_q;
    valid_out = rsp_valid_q;
    data_out  = rsp_data_q;
  end

endmodule
